// File: rtl/alpu_seq_divider_if.sv
// Operand/result bundle for the ALPU sequential divider.
// Handshake: a beat transfers on a rising edge where valid && ready; valid never waits on ready.
interface alpu_seq_divider_if #(
    parameter int REG_WIDTH = 8
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_signed;
    logic [REG_WIDTH-1:0] in_dividend;
    logic [REG_WIDTH-1:0] in_divisor;
    logic                 out_valid;
    logic                 out_ready;
    logic [REG_WIDTH-1:0] out_quotient;
    logic [REG_WIDTH-1:0] out_remainder;
    logic                 out_div_by_zero;

    modport master (
        output in_valid, in_signed, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_div_by_zero
    );

    modport slave (
        input  in_valid, in_signed, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_div_by_zero
    );
endinterface

// File: rtl/alpu_seq_divider.sv
// Restoring divider, one quotient bit per cycle; the trial subtraction reuses the ALPU
// inverter plus a two-half carry-lookahead adder. Signed ops go through magnitude and sign fix-up.
module alpu_seq_divider #(
    parameter int REG_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    alpu_seq_divider_if.slave   bus,
    output logic [2:0]          dbg_state
);
    localparam int RW    = REG_WIDTH + 1;
    localparam int LO_W  = RW / 2;
    localparam int HI_W  = RW - LO_W;
    localparam int CNT_W = $clog2(REG_WIDTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        ITER = 3'd2,
        POST = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [REG_WIDTH-1:0] dvd_q;
    logic [REG_WIDTH-1:0] dsr_q;
    logic [REG_WIDTH-1:0] orig_q;
    logic [REG_WIDTH-1:0] rem_q;
    logic [REG_WIDTH-1:0] quo_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 signed_q;
    logic                 dvd_neg_q;
    logic                 dsr_neg_q;
    logic                 dz_q;

    logic [REG_WIDTH-1:0] res_quo_q;
    logic [REG_WIDTH-1:0] res_rem_q;
    logic                 res_dz_q;

    function automatic logic [REG_WIDTH-1:0] alpu_invert(input logic [REG_WIDTH-1:0] x);
        return ~x;
    endfunction

    function automatic logic [REG_WIDTH-1:0] negate(input logic [REG_WIDTH-1:0] x);
        return alpu_invert(x) + REG_WIDTH'(1);
    endfunction

    // Lower adder half: returns {carry_out, sum} so the carry can feed the upper half.
    function automatic logic [LO_W:0] cla_lo(input logic [LO_W-1:0] a,
                                             input logic [LO_W-1:0] b,
                                             input logic            cin);
        logic [LO_W-1:0] g;
        logic [LO_W-1:0] p;
        logic [LO_W:0]   c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        for (int i = 0; i < LO_W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[LO_W], p ^ c[LO_W-1:0]};
    endfunction

    function automatic logic [HI_W-1:0] cla_hi(input logic [HI_W-1:0] a,
                                               input logic [HI_W-1:0] b,
                                               input logic            cin);
        logic [HI_W-1:0] g;
        logic [HI_W-1:0] p;
        logic [HI_W:0]   c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        for (int i = 0; i < HI_W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return p ^ c[HI_W-1:0];
    endfunction

    // Trial subtraction rem_shift - divisor at REG_WIDTH+1 bits; MSB set means it went negative.
    logic [RW-1:0]   rem_shift;
    logic [RW-1:0]   trial_b;
    logic [LO_W:0]   lo_res;
    logic [HI_W-1:0] hi_res;
    logic [RW-1:0]   trial;
    logic            trial_neg;

    always_comb begin
        rem_shift = {rem_q, dvd_q[REG_WIDTH-1]};
        trial_b   = ~{1'b0, dsr_q};
        lo_res    = cla_lo(rem_shift[LO_W-1:0], trial_b[LO_W-1:0], 1'b1);
        hi_res    = cla_hi(rem_shift[RW-1:LO_W], trial_b[RW-1:LO_W], lo_res[LO_W]);
        trial     = {hi_res, lo_res[LO_W-1:0]};
        trial_neg = trial[RW-1];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = PRE;
            PRE:     state_d = ITER;
            ITER:    if (cnt_q == '0) state_d = POST;
            POST:    state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            dvd_q     <= '0;
            dsr_q     <= '0;
            orig_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            signed_q  <= 1'b0;
            dvd_neg_q <= 1'b0;
            dsr_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            res_quo_q <= '0;
            res_rem_q <= '0;
            res_dz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        dvd_q    <= bus.in_dividend;
                        dsr_q    <= bus.in_divisor;
                        orig_q   <= bus.in_dividend;
                        signed_q <= bus.in_signed;
                    end
                end
                PRE: begin
                    dz_q      <= (dsr_q == '0);
                    dvd_neg_q <= signed_q & dvd_q[REG_WIDTH-1];
                    dsr_neg_q <= signed_q & dsr_q[REG_WIDTH-1];
                    if (signed_q && dvd_q[REG_WIDTH-1]) dvd_q <= negate(dvd_q);
                    if (signed_q && dsr_q[REG_WIDTH-1]) dsr_q <= negate(dsr_q);
                    rem_q <= '0;
                    quo_q <= '0;
                    cnt_q <= CNT_W'(REG_WIDTH - 1);
                end
                ITER: begin
                    rem_q <= trial_neg ? rem_shift[REG_WIDTH-1:0] : trial[REG_WIDTH-1:0];
                    dvd_q <= {dvd_q[REG_WIDTH-2:0], 1'b0};
                    quo_q <= {quo_q[REG_WIDTH-2:0], ~trial_neg};
                    if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
                end
                POST: begin
                    // A zero divisor overrides the sign fix-up and reports the untouched dividend.
                    if (dz_q) begin
                        res_quo_q <= '1;
                        res_rem_q <= orig_q;
                        res_dz_q  <= 1'b1;
                    end else begin
                        res_quo_q <= (dvd_neg_q ^ dsr_neg_q) ? negate(quo_q) : quo_q;
                        res_rem_q <= dvd_neg_q ? negate(rem_q) : rem_q;
                        res_dz_q  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready        = (state_q == IDLE);
    assign bus.out_valid       = (state_q == DONE);
    assign bus.out_quotient    = res_quo_q;
    assign bus.out_remainder   = res_rem_q;
    assign bus.out_div_by_zero = res_dz_q;
    assign dbg_state           = 3'(state_q);
endmodule
